// File: rtl/cond_check_pipe_pkg.sv
// Shared definitions for the condition-check pipeline slot and the branch-unit condition evaluator:
// condition-field encodings, NZCV bit positions and the flag-word type.
package cond_check_pipe_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] nzcv_t;
  typedef logic [3:0] cond_t;

  localparam cond_t COND_EQ = 4'h0;
  localparam cond_t COND_NE = 4'h1;
  localparam cond_t COND_CS = 4'h2;
  localparam cond_t COND_CC = 4'h3;
  localparam cond_t COND_MI = 4'h4;
  localparam cond_t COND_PL = 4'h5;
  localparam cond_t COND_VS = 4'h6;
  localparam cond_t COND_VC = 4'h7;
  localparam cond_t COND_HI = 4'h8;
  localparam cond_t COND_LS = 4'h9;
  localparam cond_t COND_GE = 4'hA;
  localparam cond_t COND_LT = 4'hB;
  localparam cond_t COND_GT = 4'hC;
  localparam cond_t COND_LE = 4'hD;
  localparam cond_t COND_AL = 4'hE;
  localparam cond_t COND_NV = 4'hF;

endpackage

// File: rtl/cond_check_pipe_if.sv
// Slot handshake bundle: upstream valid/ready with condition and payload, downstream valid/ready with result.
interface cond_check_pipe_if #(
  parameter int PAYLOAD_W = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_cond;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_pass;
  logic [PAYLOAD_W-1:0] out_payload;

  modport master (
    output in_valid, in_cond, in_payload, out_ready,
    input  in_ready, out_valid, out_pass, out_payload
  );

  modport slave (
    input  in_valid, in_cond, in_payload, out_ready,
    output in_ready, out_valid, out_pass, out_payload
  );
endinterface

// File: rtl/cond_check_pipe_cond_eval.sv
// Pure combinational ARM condition evaluator: (cond, NZCV) -> pass. Also used by the branch unit.
module cond_eval
  import cond_check_pipe_pkg::*;
(
  input  cond_t i_cond,
  input  nzcv_t i_flags,
  output logic  o_pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c & !w_z;
      COND_LS: o_pass = !w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_check_pipe.sv
// ID/EXE condition-check slot: owns NZCV, evaluates the condition field, keeps saturating exec/squash counts.
// Build option COND_FWD_EN: an instruction accepted alongside a status write sees the new flags.
module cond_check_pipe
  import cond_check_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_sr_we,
  input  nzcv_t             i_sr_wdata,
  cond_check_pipe_if.slave  s_bus,
  output nzcv_t             o_sr_q,
  output logic [CNT_W-1:0]  o_cnt_exec,
  output logic [CNT_W-1:0]  o_cnt_squash
);

  logic                 r_valid;
  logic                 r_pass;
  logic [PAYLOAD_W-1:0] r_payload;
  nzcv_t                r_sr;
  logic [CNT_W-1:0]     r_cnt_exec;
  logic [CNT_W-1:0]     r_cnt_squash;

  nzcv_t w_flags_eff;
  logic  w_pass;
  logic  w_in_ready;
  logic  w_accept;

`ifdef COND_FWD_EN
  assign w_flags_eff = i_sr_we ? i_sr_wdata : r_sr;
`else
  // Without the bypass the hazard unit stalls an instruction issued alongside a flag write.
  assign w_flags_eff = r_sr;
`endif

  cond_eval u_cond_eval (
    .i_cond  (s_bus.in_cond),
    .i_flags (w_flags_eff),
    .o_pass  (w_pass)
  );

  assign w_in_ready = !i_flush && (!r_valid || s_bus.out_ready);
  assign w_accept   = s_bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_pass       <= 1'b0;
      r_payload    <= '0;
      r_sr         <= '0;
      r_cnt_exec   <= '0;
      r_cnt_squash <= '0;
    end else begin
      if (i_sr_we) r_sr <= i_sr_wdata;
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_pass    <= w_pass;
        r_payload <= s_bus.in_payload;
        if (w_pass) begin
          if (r_cnt_exec != '1) r_cnt_exec <= r_cnt_exec + 1'b1;
        end else begin
          if (r_cnt_squash != '1) r_cnt_squash <= r_cnt_squash + 1'b1;
        end
      end else if (i_flush || s_bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign s_bus.in_ready    = w_in_ready;
  assign s_bus.out_valid   = r_valid;
  assign s_bus.out_pass    = r_pass;
  assign s_bus.out_payload = r_payload;
  assign o_sr_q            = r_sr;
  assign o_cnt_exec        = r_cnt_exec;
  assign o_cnt_squash      = r_cnt_squash;

endmodule

// File: tb/tb_cond_check_pipe.sv
// Randomised scoreboard bench for cond_check_pipe; a second CNT_W=2 instance shadows the stimulus for saturation.
module tb_cond_check_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       sr_we = 1'b0;
  logic [3:0] sr_wdata = 4'h0;

  logic [3:0]  sr_q;
  logic [15:0] cnt_exec;
  logic [15:0] cnt_squash;
  logic [3:0]  sr_q_s;
  logic [1:0]  cnt_exec_s;
  logic [1:0]  cnt_squash_s;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit        pass;
    bit [31:0] payload;
  } item_t;

  item_t sbq[$];

  bit        m_valid = 1'b0;
  bit        m_pass = 1'b0;
  bit [31:0] m_payload = 32'h0;
  bit [3:0]  m_sr = 4'h0;
  int        m_npass = 0;
  int        m_nfail = 0;

  cond_check_pipe_if #(.PAYLOAD_W(32)) if_m ();
  cond_check_pipe_if #(.PAYLOAD_W(32)) if_s ();

  assign if_s.in_valid   = if_m.in_valid;
  assign if_s.in_cond    = if_m.in_cond;
  assign if_s.in_payload = if_m.in_payload;
  assign if_s.out_ready  = if_m.out_ready;

  cond_check_pipe #(.PAYLOAD_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (flush),
    .i_sr_we      (sr_we),
    .i_sr_wdata   (sr_wdata),
    .s_bus        (if_m.slave),
    .o_sr_q       (sr_q),
    .o_cnt_exec   (cnt_exec),
    .o_cnt_squash (cnt_squash)
  );

  cond_check_pipe #(.PAYLOAD_W(32), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (flush),
    .i_sr_we      (sr_we),
    .i_sr_wdata   (sr_wdata),
    .s_bus        (if_s.slave),
    .o_sr_q       (sr_q_s),
    .o_cnt_exec   (cnt_exec_s),
    .o_cnt_squash (cnt_squash_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Pairs of conditions share a base predicate; the odd member is its complement.
  function automatic bit ref_pass(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  always @(negedge rst_n) begin
    m_valid = 1'b0; m_pass = 1'b0; m_payload = 32'h0; m_sr = 4'h0;
    m_npass = 0; m_nfail = 0;
    sbq.delete();
  end

  // Reference model: advances the expected state from the inputs that will be sampled at the next edge.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      bit [3:0] feff;
      bit       rdy, acc, p;
`ifdef COND_FWD_EN
      feff = sr_we ? sr_wdata : m_sr;
`else
      feff = m_sr;
`endif
      rdy = !flush && (!m_valid || if_m.out_ready);
      acc = if_m.in_valid && rdy;
      if (acc) begin
        p = ref_pass(if_m.in_cond, feff);
        sbq.push_back('{pass: p, payload: if_m.in_payload});
        m_valid = 1'b1; m_pass = p; m_payload = if_m.in_payload;
        if (p) m_npass++; else m_nfail++;
      end else if (flush || if_m.out_ready) begin
        m_valid = 1'b0;
      end
      if (sr_we) m_sr = sr_wdata;
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard and the model state.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("out_valid", 64'(if_m.out_valid), 64'(m_valid));
      chk("in_ready", 64'(if_m.in_ready), 64'(!flush && (!m_valid || if_m.out_ready)));
      if (m_valid && if_m.out_valid) begin
        if (sbq.size() == 0) begin
          chk("sb_nonempty", 64'(0), 64'(1));
        end else begin
          chk("out_pass", 64'(if_m.out_pass), 64'(sbq[0].pass));
          chk("out_payload", 64'(if_m.out_payload), 64'(sbq[0].payload));
        end
      end else begin
        chk("held_pass", 64'(if_m.out_pass), 64'(m_pass));
        chk("held_payload", 64'(if_m.out_payload), 64'(m_payload));
      end
      if (m_valid && (if_m.out_ready || flush) && sbq.size() != 0) void'(sbq.pop_front());
      chk("sr_q", 64'(sr_q), 64'(m_sr));
      chk("cnt_exec", 64'(cnt_exec), 64'(sat(m_npass, 65535)));
      chk("cnt_squash", 64'(cnt_squash), 64'(sat(m_nfail, 65535)));
      chk("cnt_exec_w2", 64'(cnt_exec_s), 64'(sat(m_npass, 3)));
      chk("cnt_squash_w2", 64'(cnt_squash_s), 64'(sat(m_nfail, 3)));
    end
  end

  task automatic drive(input bit v, input bit [3:0] c, input bit [31:0] p, input bit ordy,
                       input bit fl, input bit we, input bit [3:0] wd);
    @(posedge clk);
    #1;
    if_m.in_valid = v; if_m.in_cond = c; if_m.in_payload = p; if_m.out_ready = ordy;
    flush = fl; sr_we = we; sr_wdata = wd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 64'(if_m.out_valid), 64'(0));
    chk({tag, "_out_pass"}, 64'(if_m.out_pass), 64'(0));
    chk({tag, "_out_payload"}, 64'(if_m.out_payload), 64'(0));
    chk({tag, "_sr_q"}, 64'(sr_q), 64'(0));
    chk({tag, "_cnt_exec"}, 64'(cnt_exec), 64'(0));
    chk({tag, "_cnt_squash"}, 64'(cnt_squash), 64'(0));
    chk({tag, "_w2_out_valid"}, 64'(if_s.out_valid), 64'(0));
    chk({tag, "_w2_cnt_exec"}, 64'(cnt_exec_s), 64'(0));
    chk({tag, "_w2_cnt_squash"}, 64'(cnt_squash_s), 64'(0));
  endtask

  initial begin
    if_m.in_valid = 1'b0; if_m.in_cond = 4'h0; if_m.in_payload = 32'h0; if_m.out_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1; rst_n = 1'b1;

    // flags Z only, then EQ one cycle later
    drive(0, 4'h0, 32'h0, 1, 0, 1, 4'b0100);
    drive(1, 4'h0, 32'hA5A5_0001, 1, 0, 0, 4'h0);
    drive(0, 4'h0, 32'h0, 1, 0, 0, 4'h0);

    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        drive(0, 4'h0, 32'h0, 1, 0, 1, 4'(f));
        drive(1, 4'(c), {24'hC0DE00, 4'(f), 4'(c)}, 1, 0, 0, 4'h0);
      end
    end

    // stall three cycles, then back-to-back accepts
    drive(1, 4'hE, 32'h5EED_0000, 0, 0, 0, 4'h0);
    for (int i = 1; i <= 3; i++) drive(1, 4'hE, 32'h5EED_0000 + 32'(i), 0, 0, 0, 4'h0);
    for (int i = 4; i < 9; i++) drive(1, 4'(i), 32'h5EED_0000 + 32'(i), 1, 0, 0, 4'h0);
    drive(0, 4'h0, 32'h0, 1, 0, 0, 4'h0);

    // flag write and EQ accept in the same cycle
    drive(0, 4'h0, 32'h0, 1, 0, 1, 4'b0000);
    drive(1, 4'h0, 32'hF00D_0004, 1, 0, 1, 4'b0100);
    drive(0, 4'h0, 32'h0, 1, 0, 0, 4'h0);

    // flush with in_valid high, status write in the same cycle
    drive(1, 4'hE, 32'hF1_0005, 0, 0, 0, 4'h0);
    drive(1, 4'hE, 32'hF1_0006, 0, 1, 1, 4'b1010);
    drive(1, 4'hE, 32'hF1_0007, 1, 1, 0, 4'h0);
    drive(0, 4'h0, 32'h0, 1, 0, 0, 4'h0);

    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(3) != 0), 4'($urandom_range(15)), $urandom,
            ($urandom_range(2) != 0), ($urandom_range(7) == 0),
            ($urandom_range(3) == 0), 4'($urandom_range(15)));
    end

    // asynchronous reset while the slot is stalled
    drive(0, 4'h0, 32'h0, 1, 0, 1, 4'hF);
    drive(1, 4'hE, 32'hDEAD_BEEF, 0, 0, 0, 4'h0);
    drive(1, 4'hE, 32'hDEAD_BEF0, 0, 0, 0, 4'h0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    if_m.in_valid = 1'b0; if_m.out_ready = 1'b1; flush = 1'b0; sr_we = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    drive(1, 4'hE, 32'h0000_0AAA, 1, 0, 0, 4'h0);
    drive(1, 4'hF, 32'h0000_0BBB, 1, 0, 0, 4'h0);
    drive(0, 4'h0, 32'h0, 1, 0, 0, 4'h0);
    drive(0, 4'h0, 32'h0, 1, 0, 0, 4'h0);
    @(negedge clk); #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
